// File: rtl/vector_issue_sequencer.sv
// Issue sequencer between vector decode and execution: one instruction in flight,
// single-cycle result or multiply with completion strobe, then one writeback beat.
module vector_issue_sequencer #(
  parameter int unsigned DATA_LENGTH             = 128,
  parameter int unsigned RESOURCE_VECTOR_LENGTH  = 8,
  parameter int unsigned OPERATION_VECTOR_LENGTH = 8,
  parameter int unsigned VREG_ADDR_WIDTH         = 5,
  parameter int unsigned MUL_TIMEOUT             = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               instr_valid_i,
  output logic                               instr_ready_o,
  input  logic [RESOURCE_VECTOR_LENGTH-1:0]  resource_vector_i,
  input  logic [OPERATION_VECTOR_LENGTH-1:0] operation_vector_i,
  input  logic [1:0]                         vsew_i,
  input  logic [DATA_LENGTH-1:0]             vs1_i,
  input  logic [DATA_LENGTH-1:0]             vs2_i,
  input  logic [VREG_ADDR_WIDTH-1:0]         vd_addr_i,
  output logic [RESOURCE_VECTOR_LENGTH-1:0]  exe_resource_vector_o,
  output logic [OPERATION_VECTOR_LENGTH-1:0] exe_operation_vector_o,
  output logic [1:0]                         exe_vsew_o,
  output logic [DATA_LENGTH-1:0]             exe_vs1_o,
  output logic [DATA_LENGTH-1:0]             exe_vs2_o,
  output logic                               exe_request_o,
  input  logic [DATA_LENGTH-1:0]             exe_vd_i,
  input  logic                               exe_vd_complete_i,
  output logic                               wb_valid_o,
  output logic [VREG_ADDR_WIDTH-1:0]         wb_addr_o,
  output logic [DATA_LENGTH-1:0]             wb_data_o,
  output logic                               illegal_o,
  output logic                               timeout_o,
  output logic [15:0]                        retired_count_o
);

  localparam int unsigned CNT_W   = $clog2(MUL_TIMEOUT);
  localparam int unsigned MUL_BIT = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]                         state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               ready_q, ready_d;
  logic [RESOURCE_VECTOR_LENGTH-1:0]  res_q, res_d;
  logic [OPERATION_VECTOR_LENGTH-1:0] op_q, op_d;
  logic [1:0]                         vsew_q, vsew_d;
  logic [DATA_LENGTH-1:0]             vs1_q, vs1_d;
  logic [DATA_LENGTH-1:0]             vs2_q, vs2_d;
  logic [VREG_ADDR_WIDTH-1:0]         vd_addr_q, vd_addr_d;
  logic                               req_q, req_d;
  logic                               wb_valid_q, wb_valid_d;
  logic [VREG_ADDR_WIDTH-1:0]         wb_addr_q, wb_addr_d;
  logic [DATA_LENGTH-1:0]             wb_data_q, wb_data_d;
  logic                               illegal_q, illegal_d;
  logic                               timeout_q, timeout_d;
  logic [15:0]                        retired_q, retired_d;

  function automatic logic is_legal(input logic [RESOURCE_VECTOR_LENGTH-1:0] rv);
    return (rv == RESOURCE_VECTOR_LENGTH'(8'h01)) || (rv == RESOURCE_VECTOR_LENGTH'(8'h04)) ||
           (rv == RESOURCE_VECTOR_LENGTH'(8'h08)) || (rv == RESOURCE_VECTOR_LENGTH'(8'h20)) ||
           (rv == RESOURCE_VECTOR_LENGTH'(8'h80)) || (rv == RESOURCE_VECTOR_LENGTH'(8'h21));
  endfunction

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    op_d       = op_q;
    vsew_d     = vsew_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vd_addr_d  = vd_addr_q;
    req_d      = 1'b0;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    retired_d  = retired_q;

    case (state_q)
      IDLE: begin
        if (instr_valid_i && ready_q) begin
          if (is_legal(resource_vector_i)) begin
            state_d   = EXEC;
            res_d     = resource_vector_i;
            op_d      = operation_vector_i;
            vsew_d    = vsew_i;
            vs1_d     = vs1_i;
            vs2_d     = vs2_i;
            vd_addr_d = vd_addr_i;
            req_d     = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (res_q[MUL_BIT]) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_addr_d  = vd_addr_q;
          wb_data_d  = exe_vd_i;
        end
      end
      WAIT: begin
        // Completion takes priority over a timeout landing on the same cycle
        if (exe_vd_complete_i) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_addr_d  = vd_addr_q;
          wb_data_d  = exe_vd_i;
        end else if (cnt_q == CNT_W'(MUL_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          res_d     = '0;
          op_d      = '0;
          vsew_d    = '0;
          vs1_d     = '0;
          vs2_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        state_d   = IDLE;
        retired_d = retired_q + 16'd1;
        res_d     = '0;
        op_d      = '0;
        vsew_d    = '0;
        vs1_d     = '0;
        vs2_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      res_q      <= '0;
      op_q       <= '0;
      vsew_q     <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_addr_q  <= '0;
      req_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      res_q      <= res_d;
      op_q       <= op_d;
      vsew_q     <= vsew_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      vd_addr_q  <= vd_addr_d;
      req_q      <= req_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
    end
  end

  assign instr_ready_o          = ready_q;
  assign exe_resource_vector_o  = res_q;
  assign exe_operation_vector_o = op_q;
  assign exe_vsew_o             = vsew_q;
  assign exe_vs1_o              = vs1_q;
  assign exe_vs2_o              = vs2_q;
  assign exe_request_o          = req_q;
  assign wb_valid_o             = wb_valid_q;
  assign wb_addr_o              = wb_addr_q;
  assign wb_data_o              = wb_data_q;
  assign illegal_o              = illegal_q;
  assign timeout_o              = timeout_q;
  assign retired_count_o        = retired_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Bench for vector_issue_sequencer: cycle-indexed expectation timeline built from
// instruction latency rules, compared against the DUT every cycle.
module tb_vector_issue_sequencer;

  localparam int unsigned DW = 128;
  localparam int N = 1024;
  localparam int MUL_TIMEOUT = 16;
  localparam logic [DW-1:0] JUNK = {16{8'h5A}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    res_in, op_in;
  logic [1:0]    vsew_in;
  logic [DW-1:0] vs1_in, vs2_in;
  logic [4:0]    vd_addr_in;
  logic [7:0]    exe_res, exe_op;
  logic [1:0]    exe_vsew;
  logic [DW-1:0] exe_vs1, exe_vs2;
  logic          exe_req;
  logic [DW-1:0] exe_vd;
  logic          exe_complete;
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          illegal, timeout;
  logic [15:0]   retired;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // Expected outputs per cycle
  logic          exp_ready [N];
  logic          exp_req   [N];
  logic          exp_wbv   [N];
  logic          exp_ill   [N];
  logic          exp_to    [N];
  logic [7:0]    exp_res   [N];
  logic [7:0]    exp_op    [N];
  logic [1:0]    exp_vsew  [N];
  logic [DW-1:0] exp_vs1   [N];
  logic [DW-1:0] exp_vs2   [N];
  logic [4:0]    exp_wba   [N];
  logic [DW-1:0] exp_wbd   [N];
  logic [15:0]   exp_cnt   [N];

  // Observed DUT outputs per cycle, for hand-computed spot checks
  logic          obs_ready [N];
  logic          obs_req   [N];
  logic          obs_wbv   [N];
  logic          obs_ill   [N];
  logic          obs_to    [N];
  logic [4:0]    obs_wba   [N];
  logic [DW-1:0] obs_wbd   [N];
  logic [15:0]   obs_cnt   [N];

  vector_issue_sequencer dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .instr_valid_i          (instr_valid),
    .instr_ready_o          (instr_ready),
    .resource_vector_i      (res_in),
    .operation_vector_i     (op_in),
    .vsew_i                 (vsew_in),
    .vs1_i                  (vs1_in),
    .vs2_i                  (vs2_in),
    .vd_addr_i              (vd_addr_in),
    .exe_resource_vector_o  (exe_res),
    .exe_operation_vector_o (exe_op),
    .exe_vsew_o             (exe_vsew),
    .exe_vs1_o              (exe_vs1),
    .exe_vs2_o              (exe_vs2),
    .exe_request_o          (exe_req),
    .exe_vd_i               (exe_vd),
    .exe_vd_complete_i      (exe_complete),
    .wb_valid_o             (wb_valid),
    .wb_addr_o              (wb_addr),
    .wb_data_o              (wb_data),
    .illegal_o              (illegal),
    .timeout_o              (timeout),
    .retired_count_o        (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // From cycle s onward the sequencer is idle with everything cleared
  task automatic model_reset_from(input int s);
    for (int i = s; i < N; i++) begin
      exp_ready[i] = 1'b1; exp_req[i] = 1'b0; exp_wbv[i] = 1'b0;
      exp_ill[i] = 1'b0;   exp_to[i] = 1'b0;  exp_res[i] = '0;
      exp_op[i] = '0;      exp_vsew[i] = '0;  exp_vs1[i] = '0;
      exp_vs2[i] = '0;     exp_wba[i] = '0;   exp_wbd[i] = '0;
      exp_cnt[i] = '0;
    end
  endtask

  function automatic bit legal_res(input logic [7:0] r);
    return r inside {8'h01, 8'h04, 8'h08, 8'h20, 8'h80, 8'h21};
  endfunction

  // Instruction offered in cycle p; k = WAIT cycle (1-based) carrying completion, 0 = never
  task automatic model_issue(input int p, input logic [7:0] res, input logic [7:0] op,
                             input logic [1:0] vs, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [4:0] addr, input logic [DW-1:0] vd, input int k,
                             output int done);
    int wb;
    int busy_end;
    if (!legal_res(res)) begin
      exp_ill[p+1] = 1'b1;
      done = p + 1;
      return;
    end
    if (!res[5]) wb = p + 2;
    else if (k >= 1 && k <= MUL_TIMEOUT) wb = p + 2 + k;
    else wb = -1;
    busy_end = (wb >= 0) ? wb : p + 1 + MUL_TIMEOUT;
    exp_req[p+1] = 1'b1;
    for (int i = p + 1; i <= busy_end; i++) begin
      exp_ready[i] = 1'b0; exp_res[i] = res; exp_op[i] = op;
      exp_vsew[i] = vs;    exp_vs1[i] = a;   exp_vs2[i] = b;
    end
    if (wb < 0) begin
      exp_to[busy_end+1] = 1'b1;
    end else begin
      exp_wbv[wb] = 1'b1;
      for (int i = wb; i < N; i++) begin
        exp_wba[i] = addr;
        exp_wbd[i] = vd;
      end
      for (int i = wb + 1; i < N; i++) exp_cnt[i] = exp_cnt[i] + 16'd1;
    end
    done = busy_end + 1;
  endtask

  // Offer at the current negedge, play the execution side, return at the next ready cycle
  task automatic run(input logic [7:0] res, input logic [7:0] op, input logic [1:0] vs,
                     input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] addr,
                     input logic [DW-1:0] vd, input int k, input bit spur, output int p);
    int done;
    int d;
    p = cyc;
    instr_valid = 1'b1; res_in = res; op_in = op; vsew_in = vs;
    vs1_in = a; vs2_in = b; vd_addr_in = addr;
    exe_vd = JUNK; exe_complete = spur;
    model_issue(p, res, op, vs, a, b, addr, vd, k, done);
    while (cyc < done) begin
      @(negedge clk);
      d = cyc - p;
      instr_valid = 1'b0; res_in = 8'hFF; op_in = 8'hFF; vsew_in = 2'b11;
      vs1_in = JUNK; vs2_in = ~JUNK; vd_addr_in = 5'h1F;
      exe_complete = (k > 0 && d == k + 1) || (spur && d == 1);
      exe_vd = ((!res[5] && d == 1) || (k > 0 && d == k + 1)) ? vd : JUNK;
    end
  endtask

  // Per-cycle comparison against the expectation timeline
  always @(posedge clk) begin
    #1;
    if (cyc >= N) begin
      $display("FAIL timeline_overrun cyc=%0d got=%0d expected=<%0d", cyc, cyc, N);
      $fatal(1);
    end
    obs_ready[cyc] = instr_ready; obs_req[cyc] = exe_req; obs_wbv[cyc] = wb_valid;
    obs_ill[cyc] = illegal;       obs_to[cyc] = timeout;  obs_wba[cyc] = wb_addr;
    obs_wbd[cyc] = wb_data;       obs_cnt[cyc] = retired;
    chk("ready",    cyc, DW'(instr_ready), DW'(exp_ready[cyc]));
    chk("exe_req",  cyc, DW'(exe_req),     DW'(exp_req[cyc]));
    chk("exe_res",  cyc, DW'(exe_res),     DW'(exp_res[cyc]));
    chk("exe_op",   cyc, DW'(exe_op),      DW'(exp_op[cyc]));
    chk("exe_vsew", cyc, DW'(exe_vsew),    DW'(exp_vsew[cyc]));
    chk("exe_vs1",  cyc, exe_vs1,          exp_vs1[cyc]);
    chk("exe_vs2",  cyc, exe_vs2,          exp_vs2[cyc]);
    chk("wb_valid", cyc, DW'(wb_valid),    DW'(exp_wbv[cyc]));
    chk("wb_addr",  cyc, DW'(wb_addr),     DW'(exp_wba[cyc]));
    chk("wb_data",  cyc, wb_data,          exp_wbd[cyc]);
    chk("illegal",  cyc, DW'(illegal),     DW'(exp_ill[cyc]));
    chk("timeout",  cyc, DW'(timeout),     DW'(exp_to[cyc]));
    chk("retired",  cyc, DW'(retired),     DW'(exp_cnt[cyc]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    int p0, p1, p2, p3, p4, p5, pr, pw, done;
    model_reset_from(0);
    rst_n = 1'b0; instr_valid = 1'b0; res_in = '0; op_in = '0; vsew_in = '0;
    vs1_in = '0; vs2_in = '0; vd_addr_in = '0; exe_vd = '0; exe_complete = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // vadd
    run(8'h01, 8'h11, 2'd0, {16{8'h01}}, {16{8'h01}}, 5'd3, {16{8'h02}}, 0, 1'b0, p0);
    chk("lit_vadd_req",   p0 + 1, DW'(obs_req[p0+1]), DW'(1));
    chk("lit_vadd_wbv",   p0 + 2, DW'(obs_wbv[p0+2]), DW'(1));
    chk("lit_vadd_addr",  p0 + 2, DW'(obs_wba[p0+2]), DW'(3));
    chk("lit_vadd_data",  p0 + 2, obs_wbd[p0+2], {16{8'h02}});
    chk("lit_vadd_cnt",   p0 + 3, DW'(obs_cnt[p0+3]), DW'(1));
    chk("lit_vadd_ready", p0 + 3, DW'(obs_ready[p0+3]), DW'(1));

    // vmul, completion on the 4th WAIT cycle
    run(8'h20, 8'h42, 2'd2, {4{32'h0000_0003}}, {4{32'h0000_0007}}, 5'd9, {4{32'hDEADBEEF}}, 4, 1'b0, p1);
    chk("lit_vmul_wbv_early", p1 + 5, DW'(obs_wbv[p1+5]), DW'(0));
    chk("lit_vmul_wbv",       p1 + 6, DW'(obs_wbv[p1+6]), DW'(1));
    chk("lit_vmul_data",      p1 + 6, obs_wbd[p1+6], {4{32'hDEADBEEF}});

    // back-to-back single-cycle units
    run(8'h04, 8'h03, 2'd1, {8{16'hF0F0}}, {8{16'h0FF0}}, 5'd1, {8{16'h00F0}}, 0, 1'b0, p5);
    run(8'h08, 8'h05, 2'd3, {4{32'h8000_0001}}, {4{32'd1}}, 5'd30, {4{32'h4000_0000}}, 0, 1'b0, p5);
    run(8'h80, 8'h07, 2'd0, {16{8'hAA}}, {16{8'h55}}, 5'd31, {16{8'hAA}}, 0, 1'b0, p5);

    // multiply-add that never completes
    run(8'h21, 8'h81, 2'd2, {4{32'd5}}, {4{32'd6}}, 5'd12, {4{32'hCAFE0000}}, 0, 1'b0, p2);
    chk("lit_to_pulse", p2 + 18, DW'(obs_to[p2+18]), DW'(1));
    chk("lit_to_early", p2 + 17, DW'(obs_to[p2+17]), DW'(0));
    chk("lit_to_ready", p2 + 18, DW'(obs_ready[p2+18]), DW'(1));
    chk("lit_to_cnt",   p2 + 18, DW'(obs_cnt[p2+18]), DW'(5));

    // illegal resource patterns
    run(8'h03, 8'h01, 2'd0, JUNK, JUNK, 5'd4, JUNK, 0, 1'b0, p3);
    chk("lit_ill_03", p3 + 1, DW'(obs_ill[p3+1]), DW'(1));
    run(8'h00, 8'h01, 2'd0, JUNK, JUNK, 5'd4, JUNK, 0, 1'b0, p3);
    chk("lit_ill_00",     p3 + 1, DW'(obs_ill[p3+1]), DW'(1));
    chk("lit_ill_no_req", p3 + 1, DW'(obs_req[p3+1]), DW'(0));

    // completion on the final WAIT cycle beats the timeout
    run(8'h20, 8'h42, 2'd1, {4{32'd9}}, {4{32'd9}}, 5'd17, {4{32'h0000_0051}}, 16, 1'b0, p4);
    chk("lit_late_wbv", p4 + 18, DW'(obs_wbv[p4+18]), DW'(1));
    chk("lit_late_to",  p4 + 18, DW'(obs_to[p4+18]), DW'(0));

    // spurious completion in IDLE and EXEC, real one on WAIT cycle 3
    run(8'h20, 8'h40, 2'd0, {16{8'h11}}, {16{8'h22}}, 5'd6, {16{8'h33}}, 3, 1'b1, p5);

    // reset in the middle of WAIT, with a handshake offered while held in reset
    pr = cyc;
    instr_valid = 1'b1; res_in = 8'h20; op_in = 8'h42; vsew_in = 2'd2;
    vs1_in = {4{32'd2}}; vs2_in = {4{32'd3}}; vd_addr_in = 5'd8; exe_vd = JUNK;
    model_issue(pr, 8'h20, 8'h42, 2'd2, {4{32'd2}}, {4{32'd3}}, 5'd8, JUNK, 0, done);
    repeat (6) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
    rst_n = 1'b0;
    model_reset_from(cyc + 1);
    instr_valid = 1'b1; res_in = 8'h01; vd_addr_in = 5'd2;
    repeat (2) @(negedge clk);
    chk("lit_rst_ready", pr + 7, DW'(obs_ready[pr+7]), DW'(1));
    chk("lit_rst_cnt",   pr + 7, DW'(obs_cnt[pr+7]), DW'(0));
    instr_valid = 1'b0;
    rst_n = 1'b1;

    run(8'h04, 8'h02, 2'd0, {16{8'hC3}}, {16{8'h3C}}, 5'd10, {16{8'hFF}}, 0, 1'b0, p5);
    chk("lit_post_rst_cnt", p5 + 3, DW'(obs_cnt[p5+3]), DW'(1));

    // retirement counter wrap
    force dut.retired_q = 16'hFFFF;
    for (int i = cyc + 1; i < N; i++) exp_cnt[i] = 16'hFFFF;
    @(negedge clk);
    release dut.retired_q;
    run(8'h01, 8'h11, 2'd0, {16{8'h01}}, {16{8'h01}}, 5'd5, {16{8'h77}}, 0, 1'b0, pw);
    chk("lit_wrap_pre", pw + 2, DW'(obs_cnt[pw+2]), DW'(16'hFFFF));
    chk("lit_wrap",     pw + 3, DW'(obs_cnt[pw+3]), DW'(0));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
Front-end controller that feeds the vector execution stage and collects its result. It accepts one decoded vector instruction (operands already read) through a valid/ready handshake and drives resource/operation vectors and operands into execution. For single-cycle units it captures vd on the issue cycle; for the multiply path it raises a request and waits for the completion strobe. It then presents one writeback beat to the vector register file.

Parameters:
DATA_LENGTH, 128, operand/result width
RESOURCE_VECTOR_LENGTH, 8, resource one-hot field width (bit0 vadd, bit2 vlogic, bit3 vshft, bit5 vmul, bit7 vmerge)
OPERATION_VECTOR_LENGTH, 8, operation control field width
VREG_ADDR_WIDTH, 5, destination register index width
MUL_TIMEOUT, 16, max WAIT cycles before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  sequencer can accept
resource_vector_i  in  RESOURCE_VECTOR_LENGTH  decoded resource vector
operation_vector_i  in  OPERATION_VECTOR_LENGTH  decoded operation vector
vsew_i  in  2  element width
vs1_i, vs2_i  in  DATA_LENGTH  source operands
vd_addr_i  in  VREG_ADDR_WIDTH  destination index
exe_resource_vector_o  out  RESOURCE_VECTOR_LENGTH  to execution
exe_operation_vector_o  out  OPERATION_VECTOR_LENGTH  to execution
exe_vsew_o  out  2  to execution
exe_vs1_o, exe_vs2_o  out  DATA_LENGTH  to execution
exe_request_o  out  1  one-cycle launch strobe
exe_vd_i  in  DATA_LENGTH  execution result
exe_vd_complete_i  in  1  multiply result valid
wb_valid_o  out  1  writeback beat
wb_addr_o  out  VREG_ADDR_WIDTH  writeback index
wb_data_o  out  DATA_LENGTH  writeback data
illegal_o  out  1  one-cycle pulse: instruction rejected
timeout_o  out  1  one-cycle pulse: multiply aborted
retired_count_o  out  16  writebacks completed, wraps 0xFFFF->0

Behaviour:
- Clock clk_i; reset rst_ni asynchronous, active-low. Reset: state IDLE; all exe_* outputs, wb_*, illegal_o, timeout_o, retired_count_o = 0; instr_ready_o = 1 (decoded from IDLE). Handshakes seen while rst_ni is low are ignored.
- States: IDLE, EXEC, WAIT, WB. instr_ready_o = 1 only in IDLE.
- IDLE: on instr_valid_i & instr_ready_o, latch all instruction fields.
  - Legal resource patterns: 0x01, 0x04, 0x08, 0x20, 0x80, and 0x21 (multiply-add).
  - Legal -> EXEC. Otherwise -> stay IDLE, illegal_o = 1 next cycle, nothing issued.
- EXEC (1 cycle): exe_* = latched fields; exe_request_o = 1.
  - bit5 clear: register exe_vd_i into wb_data_o at end of cycle -> WB.
  - bit5 set: -> WAIT with counter cleared.
- WAIT: exe_request_o = 0; exe_* held stable; counter increments each cycle.
  - exe_vd_complete_i = 1: capture exe_vd_i -> WB. Completion wins over timeout in the same cycle.
  - Else if counter == MUL_TIMEOUT-1: timeout_o pulse, -> IDLE, no writeback.
- WB (1 cycle): wb_valid_o = 1, wb_addr_o = latched vd_addr; retired_count_o += 1 -> IDLE.
- exe_vd_complete_i is ignored outside WAIT.
- exe_* return to 0 in IDLE. wb_data_o/wb_addr_o hold their last value; only wb_valid_o qualifies them.
- Latency, accept edge = cycle 0:
  - Single-cycle op: EXEC cycle 1, WB cycle 2, ready again cycle 3.
  - Multiply completing k cycles after entering WAIT: WB at cycle 2+k.
- Throughput: at most one instruction in flight; no overlap between WB and accept.
- Reset asserted in any state aborts: no wb_valid_o, no pulses, counters cleared.

Test Plan:
- Reset, then vadd (res=0x01, vs1=vs2=0x…01 per byte, exe_vd_i=0x…02, vd_addr=3) -> exe_request_o high cycle 1; wb_valid_o cycle 2 with addr 3, data 0x…02; retired_count_o=1; ready high cycle 3.
- vmul (res=0x20), complete asserted 4 cycles into WAIT with vd=0xDEAD… -> single wb_valid_o at cycle 6 with that data; exe_request_o high only cycle 1; operands stable through WAIT.
- Multiply-add res=0x21, complete never asserted -> timeout_o pulses after 16 WAIT cycles; no wb_valid_o; ready returns next cycle; retired_count_o unchanged.
- Illegal res=0x03 and res=0x00 -> illegal_o pulse each, exe_request_o never asserted, state stays IDLE.
- Complete and timeout in the same cycle (complete on counter=15) -> writeback occurs, no timeout_o. Spurious complete in IDLE/EXEC -> ignored.
- Assert rst_ni low mid-WAIT -> all outputs 0 immediately, ready=1, subsequent vlogic executes normally. Preload 0xFFFF retirements -> next WB wraps retired_count_o to 0.
